// File: rtl/avr_io_tick_timer.sv
// 16-bit down-counting I/O timer with prescaler, auto-reload/one-shot modes and level IRQ on underflow.
// Zero-latency combinational reads; a CNT_LO read latches the high byte so 16-bit reads are atomic.
module avr_io_tick_timer #(
   parameter int CNT_WIDTH = 16,
   parameter int PRE_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       io_re,
   input  logic       io_we,
   input  logic [1:0] io_a,
   output logic [7:0] io_do,
   input  logic [7:0] io_di,
   output logic       irq,
   input  logic       irq_ack
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CNT_LO = 2'd2;
   localparam logic [1:0] A_CNT_HI = 2'd3;

   logic                 en_q, en_d;
   logic                 ie_q, ie_d;
   logic                 auto_q, auto_d;
   logic [1:0]           ps_q, ps_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] reload_q, reload_d;
   logic [7:0]           temp_lo_q, temp_lo_d;
   logic [7:0]           shadow_hi_q, shadow_hi_d;
   logic [PRE_WIDTH-1:0] pre_q, pre_d;

   logic                 wr_ctrl, wr_status, wr_lo, wr_hi, rd_lo;
   logic [PRE_WIDTH-1:0] pre_term;
   logic                 tick, underflow, ovf_clr;

   assign wr_ctrl   = io_we && (io_a == A_CTRL);
   assign wr_status = io_we && (io_a == A_STATUS);
   assign wr_lo     = io_we && (io_a == A_CNT_LO);
   assign wr_hi     = io_we && (io_a == A_CNT_HI);
   assign rd_lo     = io_re && (io_a == A_CNT_LO);

   always_comb begin
      pre_term = '0;
      case (ps_q)
         2'b00:   pre_term = '0;
         2'b01:   pre_term = PRE_WIDTH'(7);
         2'b10:   pre_term = PRE_WIDTH'(63);
         default: pre_term = PRE_WIDTH'(255);
      endcase
   end

   // A PS change that lands below the current prescaler value lets it wrap naturally.
   assign tick      = en_q && (pre_q == pre_term);
   assign underflow = tick && (count_q == '0);
   assign ovf_clr   = irq_ack || (wr_status && io_di[0]);

   always_comb begin
      en_d        = en_q;
      ie_d        = ie_q;
      auto_d      = auto_q;
      ps_d        = ps_q;
      ovf_d       = ovf_q;
      count_d     = count_q;
      reload_d    = reload_q;
      temp_lo_d   = temp_lo_q;
      shadow_hi_d = shadow_hi_q;
      pre_d       = pre_q;

      if (!en_q || tick) pre_d = '0;
      else               pre_d = pre_q + 1'b1;

      if (wr_hi) begin
         reload_d = {io_di, temp_lo_q};
         count_d  = {io_di, temp_lo_q};
      end else if (tick) begin
         if (count_q != '0) count_d = count_q - 1'b1;
         else if (auto_q)   count_d = reload_q;
      end

      if (wr_ctrl) begin
         en_d   = io_di[0];
         ie_d   = io_di[1];
         auto_d = io_di[2];
         ps_d   = io_di[5:4];
      end else if (underflow && !auto_q) begin
         en_d = 1'b0;
      end

      // Set beats clear when both land on one edge.
      if (underflow)    ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;

      if (wr_lo) temp_lo_d   = io_di;
      if (rd_lo) shadow_hi_d = count_q[15:8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         ie_q        <= 1'b0;
         auto_q      <= 1'b0;
         ps_q        <= 2'b00;
         ovf_q       <= 1'b0;
         count_q     <= '0;
         reload_q    <= '0;
         temp_lo_q   <= '0;
         shadow_hi_q <= '0;
         pre_q       <= '0;
      end else begin
         en_q        <= en_d;
         ie_q        <= ie_d;
         auto_q      <= auto_d;
         ps_q        <= ps_d;
         ovf_q       <= ovf_d;
         count_q     <= count_d;
         reload_q    <= reload_d;
         temp_lo_q   <= temp_lo_d;
         shadow_hi_q <= shadow_hi_d;
         pre_q       <= pre_d;
      end
   end

   always_comb begin
      io_do = 8'h00;
      if (io_re) begin
         case (io_a)
            A_CTRL:   io_do = {2'b00, ps_q, 1'b0, auto_q, ie_q, en_q};
            A_STATUS: io_do = {6'b000000, en_q, ovf_q};
            A_CNT_LO: io_do = count_q[7:0];
            default:  io_do = shadow_hi_q;
         endcase
      end
   end

   assign irq = ovf_q && ie_q;

endmodule
